irq_priority_sequencer: RTL and testbench

- Arbitrates the masked pending-interrupt vector of the APB interrupt controller and drives the single core IRQ port, which uses a req/ack handshake.
- Selects one winner per the per-line priority and holds the request until the core acknowledges it.
- Issues a one-cycle clear to the pending register file, then re-arbitrates.
- Sits between the controller's register file and the core, replacing the ad-hoc find-first-one logic.

---
 rtl/irq_seq_pkg.sv | 13 +
 rtl/irq_prio_tree.sv | 54 +++++
 rtl/irq_priority_sequencer.sv | 105 ++++++++++
 tb/tb_irq_priority_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt priority sequencer.
package irq_seq_pkg;

  typedef enum logic [1:0] {IDLE, REQ, CLEAR} irq_seq_state_e;

  localparam int unsigned DefaultPrioW = 2;

  // Smallest id width able to number num_irq lines (at least one bit).
  function automatic int unsigned min_id_w(input int unsigned num_irq);
    return (num_irq > 1) ? $clog2(num_irq) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_tree.sv
// Combinational max-priority finder; on equal priority the lowest index wins.
module irq_prio_tree #(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned PRIO_W  = 2,
  parameter int unsigned ID_W    = 5
) (
  input  logic [NUM_IRQ-1:0]        cand_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
  output logic                      valid_o,
  output logic [ID_W-1:0]           id_o,
  output logic [PRIO_W-1:0]         prio_o
);

  localparam int unsigned Lvls   = $clog2(NUM_IRQ);
  localparam int unsigned Leaves = 2 ** Lvls;
  localparam int unsigned PadW   = Leaves * PRIO_W;

  logic [Leaves-1:0] cand_pad;
  logic [PadW-1:0]   prio_pad;
  logic [Leaves-1:0] node_v;
  logic [PRIO_W-1:0] node_p  [Leaves];
  logic [ID_W-1:0]   node_id [Leaves];

  assign cand_pad = Leaves'(cand_i);
  assign prio_pad = PadW'(prio_i);

  // Pairwise reduction in place: each level halves the live nodes. Node n
  // reads 2n/2n+1, which are never overwritten before being read.
  always_comb begin
    for (int k = 0; k < Leaves; k++) begin
      node_v[k]  = cand_pad[k];
      node_p[k]  = prio_pad[k*PRIO_W +: PRIO_W];
      node_id[k] = ID_W'(k);
    end
    for (int l = 0; l < Lvls; l++) begin
      for (int n = 0; n < (Leaves >> (l + 1)); n++) begin
        if (node_v[2*n+1] && (!node_v[2*n] || (node_p[2*n+1] > node_p[2*n]))) begin
          node_v[n]  = 1'b1;
          node_p[n]  = node_p[2*n+1];
          node_id[n] = node_id[2*n+1];
        end else begin
          node_v[n]  = node_v[2*n] | node_v[2*n+1];
          node_p[n]  = node_p[2*n];
          node_id[n] = node_id[2*n];
        end
      end
    end
  end

  assign valid_o = node_v[0];
  assign id_o    = node_id[0];
  assign prio_o  = node_p[0];

endmodule

// File: rtl/irq_priority_sequencer.sv
// Picks the highest-priority pending line, presents it to the core over a
// req/ack handshake and pulses a clear back to the pending register file.
module irq_priority_sequencer
  import irq_seq_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned PRIO_W      = DefaultPrioW,
  parameter int unsigned ID_W        = min_id_w(NUM_IRQ),
  parameter bit          ENA_SEC_IRQ = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [NUM_IRQ-1:0]        pending_i,
  input  logic [NUM_IRQ-1:0]        mask_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
  input  logic [NUM_IRQ-1:0]        sec_mask_i,
  output logic                      core_irq_req_o,
  output logic [ID_W-1:0]           core_irq_id_o,
  output logic                      core_irq_sec_o,
  input  logic                      core_irq_ack_i,
  input  logic [ID_W-1:0]           core_irq_id_i,
  output logic                      clr_valid_o,
  output logic [ID_W-1:0]           clr_id_o,
  output logic                      id_err_o,
  output logic                      busy_o
);

  irq_seq_state_e    state_q;
  logic              req_q, sec_q, clr_valid_q, id_err_q;
  logic [ID_W-1:0]   id_q, clr_id_q;

  logic [NUM_IRQ-1:0] cand;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio_unused;
  logic               win_sec;

  assign cand = enable_i ? (pending_i & mask_i) : '0;

  irq_prio_tree #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_tree (
    .cand_i  (cand),
    .prio_i  (prio_i),
    .valid_o (win_valid),
    .id_o    (win_id),
    .prio_o  (win_prio_unused)
  );

  always_comb begin
    win_sec = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (win_id == ID_W'(k)) win_sec = sec_mask_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      id_q        <= '0;
      sec_q       <= 1'b0;
      clr_valid_q <= 1'b0;
      clr_id_q    <= '0;
      id_err_q    <= 1'b0;
    end else begin
      clr_valid_q <= 1'b0;
      id_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            id_q    <= win_id;
            sec_q   <= win_sec;
          end
        end
        // Held id/sec never change here; only the ack moves us on.
        REQ: begin
          if (core_irq_ack_i) begin
            state_q     <= CLEAR;
            req_q       <= 1'b0;
            clr_valid_q <= 1'b1;
            clr_id_q    <= core_irq_id_i;
            id_err_q    <= (core_irq_id_i != id_q);
          end
        end
        CLEAR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_irq_req_o = req_q;
  assign core_irq_id_o  = id_q;
  assign core_irq_sec_o = ENA_SEC_IRQ ? sec_q : 1'b0;
  assign clr_valid_o    = clr_valid_q;
  assign clr_id_o       = clr_id_q;
  assign id_err_o       = id_err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Scoreboard bench: stimulus pushes expected requests/clears, a monitor checks them.
module tb_irq_priority_sequencer;

  localparam int N  = 32;
  localparam int PW = 2;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          ack = 1'b0;
  logic [N-1:0]  pending = '0;
  logic [N-1:0]  mask = '0;
  logic [N-1:0]  sec_mask = '0;
  logic [N*PW-1:0] prio = '0;
  logic [IW-1:0] ack_id = '0;

  logic          req, sec, clr_valid, id_err, busy;
  logic [IW-1:0] id, clr_id;
  logic          req2, sec2, clr2_unused, err2_unused, busy2_unused;
  logic [IW-1:0] id2_unused, clrid2_unused;

  irq_priority_sequencer #(.NUM_IRQ(N), .PRIO_W(PW), .ID_W(IW), .ENA_SEC_IRQ(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .pending_i(pending), .mask_i(mask),
    .prio_i(prio), .sec_mask_i(sec_mask), .core_irq_req_o(req), .core_irq_id_o(id),
    .core_irq_sec_o(sec), .core_irq_ack_i(ack), .core_irq_id_i(ack_id),
    .clr_valid_o(clr_valid), .clr_id_o(clr_id), .id_err_o(id_err), .busy_o(busy)
  );

  irq_priority_sequencer #(.NUM_IRQ(N), .PRIO_W(PW), .ID_W(IW), .ENA_SEC_IRQ(1'b0)) dut_nosec (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .pending_i(pending), .mask_i(mask),
    .prio_i(prio), .sec_mask_i(sec_mask), .core_irq_req_o(req2), .core_irq_id_o(id2_unused),
    .core_irq_sec_o(sec2), .core_irq_ack_i(ack), .core_irq_id_i(ack_id),
    .clr_valid_o(clr2_unused), .clr_id_o(clrid2_unused), .id_err_o(err2_unused),
    .busy_o(busy2_unused)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  typedef struct {
    int            cyc;
    logic [IW-1:0] id;
    logic          flag;
  } exp_t;

  exp_t rq[$];
  exp_t cq[$];
  int   total = 0;
  int   bad = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a request or a clear.
  exp_t          e;
  logic          req_prev = 1'b0;
  logic [IW-1:0] held_id = '0;
  logic          held_sec = 1'b0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_at_edge) begin
        check("reset_outputs", 32'({req, id, sec, clr_valid, clr_id, id_err, busy, req2}), 32'd0);
      end else begin
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
          total++; bad++;
          $display("FAIL req_missing: no request seen, expected id %0d at cycle %0d",
                   rq[0].id, rq[0].cyc);
          void'(rq.pop_front());
        end
        while (cq.size() > 0 && cq[0].cyc < cyc) begin
          total++; bad++;
          $display("FAIL clr_missing: no clear seen, expected id %0d at cycle %0d",
                   cq[0].id, cq[0].cyc);
          void'(cq.pop_front());
        end
        if (req && !req_prev) begin
          if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: got request id %0d, expected none (cycle %0d)", id, cyc);
          end else begin
            e = rq.pop_front();
            check("req_cycle", 32'(cyc), 32'(e.cyc));
            check("req_id", 32'(id), 32'(e.id));
            check("req_sec", 32'(sec), 32'(e.flag));
            held_id  = e.id;
            held_sec = e.flag;
          end
        end else if (req) begin
          check("req_stable", 32'({id, sec}), 32'({held_id, held_sec}));
        end
        if (clr_valid) begin
          if (cq.size() == 0) begin
            total++; bad++;
            $display("FAIL clr_unexpected: got clear id %0d, expected none (cycle %0d)",
                     clr_id, cyc);
          end else begin
            e = cq.pop_front();
            check("clr_cycle", 32'(cyc), 32'(e.cyc));
            check("clr_id", 32'(clr_id), 32'(e.id));
            check("clr_id_err", 32'(id_err), 32'(e.flag));
            check("clr_req_low", 32'(req), 32'd0);
          end
        end else begin
          check("id_err_idle", 32'(id_err), 32'd0);
        end
        check("busy", 32'(busy), 32'(req | clr_valid));
        if (req2) check("sec_disabled", 32'(sec2), 32'd0);
      end
    end
    req_prev = req;
  end

  // Reference: max priority among enabled & masked pending lines, lowest index on ties.
  function automatic void winner(output bit found, output logic [IW-1:0] wid);
    int bp;
    bp = -1; found = 1'b0; wid = '0;
    for (int i = 0; i < N; i++) begin
      if (enable && pending[i] && mask[i] && int'(prio[i*PW +: PW]) > bp) begin
        bp    = int'(prio[i*PW +: PW]);
        wid   = IW'(i);
        found = 1'b1;
      end
    end
  endfunction

  bit            exp_open = 1'b0;
  logic [IW-1:0] exp_id = '0;

  task automatic expect_req(input int at);
    bit            f;
    logic [IW-1:0] w;
    winner(f, w);
    exp_open = f;
    if (f) begin
      exp_id = w;
      rq.push_back('{cyc: at, id: w, flag: sec_mask[w]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int line, input int p);
    prio[line*PW +: PW] = PW'(p);
  endtask

  task automatic mutate();
    int line;
    line = int'($urandom_range(N - 1));
    pending[line] = 1'b1;
    set_prio(int'($urandom_range(N - 1)), int'($urandom_range(3)));
    line = int'($urandom_range(N - 1));
    mask[line] = ~mask[line];
    sec_mask[$urandom_range(N - 1)] = 1'($urandom);
  endtask

  // Entry: the expected request shows up at cyc+1. Exit: same, for the next one.
  task automatic serve(input int hold, input int ack_override, input bit mut);
    int            a;
    logic [IW-1:0] aid;
    repeat (1 + hold) begin
      tick();
      if (mut) mutate();
    end
    aid    = (ack_override < 0) ? exp_id : IW'(ack_override);
    ack    = 1'b1;
    ack_id = aid;
    a      = cyc;
    tick();
    ack    = 1'b0;
    ack_id = IW'($urandom);
    cq.push_back('{cyc: a + 1, id: aid, flag: (aid != exp_id)});
    pending[aid] = 1'b0;
    if (mut && $urandom_range(1) == 1) mutate();
    expect_req(a + 3);
    tick();
  endtask

  initial begin
    int ov;
    repeat (3) tick();
    rst = 1'b0;

    // Single line
    enable = 1'b1; mask = '1; sec_mask = $urandom; pending = 32'h1;
    expect_req(cyc + 1);
    serve(0, -1, 1'b0);
    repeat (2) tick();

    // Priority order with a tie: 3, 10, 11, 1
    prio = '0;
    set_prio(1, 1); set_prio(3, 3); set_prio(10, 3); set_prio(11, 2);
    pending = 32'h0000_0C0A;
    expect_req(cyc + 1);
    for (int k = 0; k < 8 && exp_open; k++) serve(0, -1, 1'b0);
    repeat (2) tick();

    // Held request stays put while a hotter line appears and its own mask drops
    prio = '0; set_prio(5, 1); set_prio(20, 3);
    pending = 32'h1 << 5;
    expect_req(cyc + 1);
    tick(); tick();
    pending[20] = 1'b1; mask[5] = 1'b0;
    serve(2, -1, 1'b0);
    for (int k = 0; k < 4 && exp_open; k++) serve(0, -1, 1'b0);
    mask = '1;
    repeat (2) tick();

    // Mismatched ack: clears 9, flags error, line 7 comes back
    pending = 32'h1 << 7;
    expect_req(cyc + 1);
    serve(1, 9, 1'b0);
    for (int k = 0; k < 4 && exp_open; k++) serve(0, -1, 1'b0);
    repeat (2) tick();

    // Spurious ack while idle, then global disable
    pending = '0;
    tick();
    ack = 1'b1; ack_id = 5'd3;
    tick();
    ack = 1'b0;
    repeat (2) tick();
    enable = 1'b0; pending = '1; sec_mask = $urandom; prio = {$urandom, $urandom};
    repeat (4) tick();
    enable = 1'b1;
    expect_req(cyc + 1);
    for (int k = 0; k < 40 && exp_open; k++) serve(0, -1, 1'b0);
    repeat (2) tick();

    // Reset during REQ: request drops, no clear, arbitration restarts
    pending = 32'h0001_0100;
    expect_req(cyc + 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_req(cyc + 1);
    for (int k = 0; k < 4 && exp_open; k++) serve(0, -1, 1'b0);
    repeat (2) tick();

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      if (!exp_open) begin
        pending  = $urandom & $urandom;
        mask     = $urandom | $urandom;
        prio     = {$urandom, $urandom};
        sec_mask = $urandom;
        enable   = ($urandom_range(7) != 0);
        expect_req(cyc + 1);
        if (!exp_open) begin
          tick(); tick();
          continue;
        end
      end
      ov = ($urandom_range(7) == 0) ?
           int'((int'(exp_id) + 1 + int'($urandom_range(30))) % N) : -1;
      serve(int'($urandom_range(3)), ov, 1'($urandom));
    end

    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
